// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes six BCD digits onto one 7-segment bus,
// with blanking between digits and frame-coherent capture of the inputs.
module seg_scan_driver #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 50
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic [5:0] dp_mask,
  output logic [0:6] seg,
  output logic       dp,
  output logic [5:0] dig_sel,
  output logic       frame_tick
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [5:0][3:0] r_dig;
  logic [5:0]      r_dpm;
  logic            w_last, w_cap, w_act;
  logic [3:0]      w_code;
  logic [6:0]      w_seg;
  assign w_last = r_cnt == CW'(SCAN_DIV - 1);
  assign w_cap  = w_last && r_idx == 3'd5;
  // idx values 6..7 are unreachable; treat them as all digits off
  assign w_act  = r_cnt >= CW'(BLANK_CYC) && r_idx < 3'd6;
  assign w_code = w_act ? r_dig[r_idx] : 4'hF;
  always_comb begin
    w_seg = 7'b0000000;
    case (w_code)
      4'd0: w_seg = 7'b1111110;
      4'd1: w_seg = 7'b0110000;
      4'd2: w_seg = 7'b1101101;
      4'd3: w_seg = 7'b1111001;
      4'd4: w_seg = 7'b0110011;
      4'd5: w_seg = 7'b1011011;
      4'd6: w_seg = 7'b0011111;
      4'd7: w_seg = 7'b1110000;
      4'd8: w_seg = 7'b1111111;
      4'd9: w_seg = 7'b1110011;
      default: w_seg = 7'b0000000;
    endcase
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt      <= '0;
      r_idx      <= 3'd0;
      r_dig      <= {6{4'hF}};
      r_dpm      <= 6'd0;
      seg        <= 7'b0000000;
      dp         <= 1'b0;
      dig_sel    <= 6'h3F;
      frame_tick <= 1'b0;
    end else begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) r_idx <= w_cap ? 3'd0 : r_idx + 3'd1;
      if (w_cap) begin
        r_dig <= {d5, d4, d3, d2, d1, d0};
        r_dpm <= dp_mask;
      end
      frame_tick <= w_cap;
      seg        <= w_seg;
      dp         <= w_act & r_dpm[r_idx];
      dig_sel    <= w_act ? ~(6'd1 << r_idx) : 6'h3F;
    end
  end
endmodule
